// File: rtl/ldtu_tx_scheduler_if.sv
// ---------------------------------------------------------------------------
// ldtu_tx_scheduler_if
// Bundles the encoder-side inputs and serializer-side outputs of the
// LiTe-DTU transmit scheduler.
//   master : encoder/serializer side (drives fallback, Load*, DATA_32*)
//   slave  : the scheduler (drives DATA_OUT, word_strobe, fifo_level,
//            overflow, mode_switch, mode)
// ---------------------------------------------------------------------------
interface ldtu_tx_scheduler_if #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          fallback;
    logic          Load;
    logic [31:0]   DATA_32;
    logic          Load_FB;
    logic [31:0]   DATA_32_FB;
    logic [31:0]   DATA_OUT;
    logic          word_strobe;
    logic [LW-1:0] fifo_level;
    logic          overflow;
    logic          mode_switch;
    logic          mode;

    modport master (
        output fallback, Load, DATA_32, Load_FB, DATA_32_FB,
        input  DATA_OUT, word_strobe, fifo_level, overflow, mode_switch, mode
    );

    modport slave (
        input  fallback, Load, DATA_32, Load_FB, DATA_32_FB,
        output DATA_OUT, word_strobe, fifo_level, overflow, mode_switch, mode
    );
endinterface

// File: rtl/ldtu_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ldtu_tx_scheduler
// Selects the active LiTe-DTU encoder stream (normal or fallback), buffers
// its words in a small circular FIFO and emits exactly one 32-bit word per
// SLOT-cycle serializer slot, inserting a mode-specific idle word when the
// FIFO is empty. Mode changes flush the FIFO and block writes until the
// next slot edge has emitted the target-mode idle word.
// Ports:
//   CLK, reset : clock, asynchronous active-high reset
//   bus.slave  : fallback, Load/DATA_32, Load_FB/DATA_32_FB in;
//                DATA_OUT, word_strobe, fifo_level, overflow,
//                mode_switch, mode out (all registered)
// ---------------------------------------------------------------------------
module ldtu_tx_scheduler #(
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned SLOT         = 4,
    parameter logic [31:0] IDLE_WORD    = 32'hEAAAAAAA,
    parameter logic [31:0] IDLE_WORD_FB = 32'h00000000
) (
    input  logic                 CLK,
    input  logic                 reset,
    ldtu_tx_scheduler_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned SW = $clog2(SLOT);

    typedef enum logic [1:0] {
        ST_NORMAL   = 2'd0,
        ST_FALLBACK = 2'd1,
        ST_SWITCH   = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_target;
    logic          r_mode;
    logic          r_mode_switch;
    logic [SW-1:0] r_slot_cnt;
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic [31:0]   r_mem [DEPTH];
    logic [31:0]   r_data_out;
    logic          r_strobe;
    logic          r_overflow;

    logic          w_slot_edge;
    logic          w_empty;
    logic          w_full;
    logic          w_req_switch;
    logic          w_wr_req;
    logic [31:0]   w_wr_data;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_idle_is_fb;
    logic [31:0]   w_idle;

    assign w_slot_edge  = (r_slot_cnt == SW'(SLOT - 1));
    assign w_empty      = (r_level == '0);
    assign w_full       = (r_level == LW'(DEPTH));

    // A mode request differing from the committed stream starts a switch.
    assign w_req_switch = ((r_state == ST_NORMAL)   &&  bus.fallback) ||
                          ((r_state == ST_FALLBACK) && !bus.fallback);

    // Only the active stream writes; the write is discarded on a switch edge.
    assign w_wr_req     = !w_req_switch &&
                          (((r_state == ST_NORMAL)   && bus.Load) ||
                           ((r_state == ST_FALLBACK) && bus.Load_FB));
    assign w_wr_data    = (r_state == ST_FALLBACK) ? bus.DATA_32_FB : bus.DATA_32;

    assign w_pop        = w_slot_edge && !w_empty && (r_state != ST_SWITCH);
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push       = w_wr_req && (!w_full || w_pop);
    assign w_drop       = w_wr_req && w_full && !w_pop;

    // Idle word follows the target mode, which during a switch is r_target.
    assign w_idle_is_fb = (r_state == ST_SWITCH) ? r_target : (r_state == ST_FALLBACK);
    assign w_idle       = w_idle_is_fb ? IDLE_WORD_FB : IDLE_WORD;

    // Free-running slot counter, unaffected by mode changes.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_slot_cnt <= '0;
        end else if (w_slot_edge) begin
            r_slot_cnt <= '0;
        end else begin
            r_slot_cnt <= r_slot_cnt + SW'(1);
        end
    end

    // Output word register and strobe, updated on every slot edge.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_data_out <= IDLE_WORD;
            r_strobe   <= 1'b0;
        end else begin
            r_strobe <= w_slot_edge;
            if (w_slot_edge) begin
                r_data_out <= w_pop ? r_mem[r_rptr] : w_idle;
            end
        end
    end

    // FIFO pointers, occupancy and sticky overflow; a switch flushes everything.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_req_switch) begin
                r_wptr  <= '0;
                r_rptr  <= '0;
                r_level <= '0;
            end else begin
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_level <= r_level + LW'(1);
                    2'b01:   r_level <= r_level - LW'(1);
                    default: r_level <= r_level;
                endcase
            end
        end
    end

    // Storage array; contents need no reset since occupancy gates all reads.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr_data;
        end
    end

    // Mode sequencer.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state       <= ST_NORMAL;
            r_target      <= 1'b0;
            r_mode        <= 1'b0;
            r_mode_switch <= 1'b0;
        end else begin
            r_mode_switch <= 1'b0;
            case (r_state)
                ST_NORMAL: begin
                    if (bus.fallback) begin
                        r_state       <= ST_SWITCH;
                        r_target      <= 1'b1;
                        r_mode_switch <= 1'b1;
                    end
                end
                ST_FALLBACK: begin
                    if (!bus.fallback) begin
                        r_state       <= ST_SWITCH;
                        r_target      <= 1'b0;
                        r_mode_switch <= 1'b1;
                    end
                end
                ST_SWITCH: begin
                    // Target tracks the request; commit on the slot edge that
                    // emits the idle word of the registered target.
                    r_target <= bus.fallback;
                    if (w_slot_edge) begin
                        r_state <= r_target ? ST_FALLBACK : ST_NORMAL;
                        r_mode  <= r_target;
                    end
                end
                default: begin
                    r_state <= ST_NORMAL;
                end
            endcase
        end
    end

    assign bus.DATA_OUT    = r_data_out;
    assign bus.word_strobe = r_strobe;
    assign bus.fifo_level  = r_level;
    assign bus.overflow    = r_overflow;
    assign bus.mode_switch = r_mode_switch;
    assign bus.mode        = r_mode;

endmodule

// File: tb/tb_ldtu_tx_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ldtu_tx_scheduler
// Drives per-cycle stimulus records into ldtu_tx_scheduler; accepted words
// go to an expected-output queue that is consumed on every slot strobe.
// ---------------------------------------------------------------------------
module tb_ldtu_tx_scheduler;
    localparam int          DEPTH  = 4;
    localparam int          SLOT   = 4;
    localparam logic [31:0] IDLE_N = 32'hEAAAAAAA;
    localparam logic [31:0] IDLE_F = 32'h00000000;

    typedef struct {
        bit          fb;
        bit          ld;
        logic [31:0] d;
        bit          ldfb;
        logic [31:0] dfb;
        bit          acc;   // word expected to be accepted into the FIFO
        int          lvl;   // expected values after the sampling edge; -1 = skip
        int          ovf;
        int          md;
        int          ms;
    } vec_t;

    logic CLK;
    logic reset;

    ldtu_tx_scheduler_if #(.DEPTH(DEPTH)) bus();

    ldtu_tx_scheduler #(
        .DEPTH        (DEPTH),
        .SLOT         (SLOT),
        .IDLE_WORD    (IDLE_N),
        .IDLE_WORD_FB (IDLE_F)
    ) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    int          total;
    int          bad;
    int          e_cnt;
    logic [31:0] exp_q [$];
    logic [31:0] exp_idle;
    bit          pend_v;
    logic [31:0] pend_w;
    vec_t        pend_c;
    vec_t        tbl [40];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Rising edges since reset release.
    always @(posedge CLK or posedge reset) begin
        if (reset) e_cnt <= 0;
        else       e_cnt <= e_cnt + 1;
    end

    function automatic vec_t mk(input bit fb, input bit ld, input logic [31:0] d,
                                input bit ldfb, input logic [31:0] dfb, input bit acc,
                                input int lvl, input int ovf, input int md, input int ms);
        vec_t v;
        v.fb = fb; v.ld = ld; v.d = d; v.ldfb = ldfb; v.dfb = dfb; v.acc = acc;
        v.lvl = lvl; v.ovf = ovf; v.md = md; v.ms = ms;
        return v;
    endfunction

    function automatic vec_t nv();
        return mk(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, -1, -1, -1, -1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t edge=%0d: got %h expected %h", nm, $time, e_cnt, act, exp);
        end
    endtask

    // Check the edge just passed, then drive the next cycle's inputs.
    task automatic step(input vec_t v);
        bit          es;
        logic [31:0] e;
        @(negedge CLK);
        es = (e_cnt > 0) && ((e_cnt % SLOT) == 0);
        chk("word_strobe", 32'(bus.word_strobe), 32'(es));
        if (es) begin
            if (exp_q.size() > 0) e = exp_q.pop_front();
            else                  e = exp_idle;
            chk("DATA_OUT", bus.DATA_OUT, e);
        end
        if (pend_c.lvl >= 0) chk("fifo_level",  32'(bus.fifo_level),  32'(pend_c.lvl));
        if (pend_c.ovf >= 0) chk("overflow",    32'(bus.overflow),    32'(pend_c.ovf));
        if (pend_c.md  >= 0) chk("mode",        32'(bus.mode),        32'(pend_c.md));
        if (pend_c.ms  >= 0) chk("mode_switch", 32'(bus.mode_switch), 32'(pend_c.ms));
        if (pend_v) exp_q.push_back(pend_w);
        pend_v = v.acc;
        pend_w = v.ldfb ? v.dfb : v.d;
        pend_c = v;
        bus.fallback   = v.fb;
        bus.Load       = v.ld;
        bus.DATA_32    = v.d;
        bus.Load_FB    = v.ldfb;
        bus.DATA_32_FB = v.dfb;
    endtask

    // Assert reset immediately, check async reset values, release on a negedge.
    task automatic do_reset();
        reset          = 1'b1;
        bus.fallback   = 1'b0;
        bus.Load       = 1'b0;
        bus.DATA_32    = 32'h0;
        bus.Load_FB    = 1'b0;
        bus.DATA_32_FB = 32'h0;
        #1;
        chk("rst_DATA_OUT",    bus.DATA_OUT, IDLE_N);
        chk("rst_word_strobe", 32'(bus.word_strobe), 32'h0);
        chk("rst_fifo_level",  32'(bus.fifo_level),  32'h0);
        chk("rst_overflow",    32'(bus.overflow),    32'h0);
        chk("rst_mode_switch", 32'(bus.mode_switch), 32'h0);
        chk("rst_mode",        32'(bus.mode),        32'h0);
        repeat (2) @(negedge CLK);
        reset    = 1'b0;
        exp_q.delete();
        exp_idle = IDLE_N;
        pend_v   = 1'b0;
        pend_c   = nv();
    endtask

    initial begin
        total = 0;
        bad   = 0;

        // Idle stream after reset: strobes on edges 4, 8, 12 carry IDLE_WORD.
        do_reset();
        for (int i = 0; i < 13; i++) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // Table: entry i is sampled on edge i+2; slot edges are 4, 8, 12, ...
        for (int i = 0; i < 40; i++) tbl[i] = nv();
        tbl[0]  = mk(0, 1, 32'h11111111, 0, 0, 1, 1, -1,  0, -1);
        tbl[1]  = mk(0, 1, 32'h22222222, 0, 0, 1, 2, -1, -1, -1);
        tbl[2]  = mk(0, 0, 0,            0, 0, 0, 1, -1, -1, -1);
        tbl[6]  = mk(0, 0, 0,            0, 0, 0, 0, -1, -1, -1);
        tbl[11] = mk(0, 1, 32'hA0A0A001, 0, 0, 1, 1, -1, -1, -1);
        tbl[12] = mk(0, 1, 32'hB0B0B002, 0, 0, 1, 2, -1, -1, -1);
        tbl[13] = mk(0, 1, 32'hC0C0C003, 0, 0, 1, 3, -1, -1, -1);
        tbl[14] = mk(0, 1, 32'hD0D0D004, 0, 0, 1, 3, -1, -1, -1);  // push+pop on slot edge
        tbl[15] = mk(0, 1, 32'hE0E0E005, 0, 0, 1, 4,  0, -1, -1);
        tbl[18] = mk(0, 1, 32'hF0F0F006, 0, 0, 1, 4,  0, -1, -1);  // full, push+pop on slot edge
        tbl[19] = mk(0, 1, 32'h0BADBAD7, 0, 0, 0, 4,  1, -1, -1);  // full, no pop: dropped
        tbl[20] = mk(0, 0, 0,            0, 0, 0, 4,  1, -1, -1);
        tbl[22] = mk(0, 0, 0,            0, 0, 0, 3, -1, -1, -1);
        tbl[26] = mk(0, 0, 0,            0, 0, 0, 2, -1, -1, -1);
        tbl[30] = mk(0, 0, 0,            0, 0, 0, 1, -1, -1, -1);
        tbl[34] = mk(0, 0, 0,            0, 0, 0, 0, -1, -1, -1);
        tbl[38] = mk(0, 0, 0,            0, 0, 0, 0,  1,  0,  0);
        do_reset();
        for (int i = 0; i < 40; i++) step(tbl[i]);

        // Switch to fallback with words queued: flush, blocked writes, idle FB word.
        do_reset();
        repeat (3) step(nv());
        step(mk(0, 1, 32'h31313131, 0, 0, 1, 1, -1, -1, -1));
        step(mk(0, 1, 32'h32323232, 0, 0, 1, 2, -1, -1, -1));
        step(mk(0, 1, 32'h33333333, 0, 0, 1, 3, -1,  0, -1));
        step(mk(0, 0, 0,            0, 0, 0, 2, -1, -1, -1));
        step(mk(1, 1, 32'hDEADBEEF, 0, 0, 0, 0, -1,  0,  1));
        exp_q.delete();
        exp_idle = IDLE_F;
        step(mk(1, 0, 0, 1, 32'h55555555, 0, 0, -1, 0, 0));
        step(mk(1, 0, 0, 0, 0,            0, 0, -1, 0, 0));
        step(mk(1, 0, 0, 0, 0,            0, 0, -1, 1, 0));
        step(mk(1, 0, 0, 1, 32'h0F0F0F0F, 1, 1, -1, 1, 0));
        step(mk(1, 1, 32'h77777777, 0, 0, 0, 1, -1, 1, 0));
        step(mk(1, 0, 0, 0, 0,            0, -1, -1, -1, -1));
        step(mk(1, 0, 0, 0, 0,            0, 0, -1, 1, -1));
        repeat (5) step(mk(1, 0, 0, 0, 0, 0, -1, -1, -1, -1));

        // Fallback raised for one cycle then dropped before the slot edge.
        do_reset();
        repeat (3) step(nv());
        step(mk(1, 0, 0, 0, 0, 0, 0, -1, 0, 1));
        step(mk(0, 0, 0, 0, 0, 0, -1, -1, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, -1, -1, 0, 0));
        step(mk(0, 0, 0, 0, 0, 0, -1, -1, 0, 0));
        step(mk(0, 1, 32'h99999999, 0, 0, 1, 1, -1, 0, 0));
        step(nv());
        step(nv());
        step(mk(0, 0, 0, 0, 0, 0, 0, -1, -1, -1));
        step(nv());

        // Reset asserted with three words held and a data word on DATA_OUT.
        do_reset();
        step(mk(0, 1, 32'hA1A1A1A1, 0, 0, 1, 1, -1, -1, -1));
        step(mk(0, 1, 32'hA2A2A2A2, 0, 0, 1, 2, -1, -1, -1));
        step(mk(0, 0, 0,            0, 0, 0, 1, -1, -1, -1));
        step(mk(0, 1, 32'hA3A3A3A3, 0, 0, 1, 2, -1, -1, -1));
        step(mk(0, 1, 32'hA4A4A4A4, 0, 0, 1, 3, -1, -1, -1));
        step(nv());
        do_reset();
        repeat (5) step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
